// File: rtl/conv_first_to_last_with_ready.sv
// Converts a first-marked stream into a last-marked stream.
// Holds one beat until the next beat or a flush reveals whether it ends a packet.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   up_valid/up_ready        upstream handshake
//   up_first, up_data        upstream first-of-packet marker and payload
//   up_flush                 closes the held packet with no following beat
//   down_valid/down_ready    downstream handshake
//   down_last, down_data     downstream last-of-packet marker and payload
//   packet_count             wrapping count of beats sent with down_last=1
//   err_no_first             sticky: a packet started without up_first
module conv_first_to_last_with_ready #(
  parameter int width       = 8,
  parameter int count_width = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic                   up_first,
  input  logic [width-1:0]       up_data,
  input  logic                   up_flush,
  output logic                   down_valid,
  input  logic                   down_ready,
  output logic                   down_last,
  output logic [width-1:0]       down_data,
  output logic [count_width-1:0] packet_count,
  output logic                   err_no_first
);

  logic             hold_valid;
  logic [width-1:0] hold_data;
  logic             expect_first;

  logic accept;
  logic xfer;
  logic xfer_last;
  logic expect_now;

  // The held beat can only leave once its successor (or a flush)
  // tells us whether it is the last beat of its packet.
  assign down_valid = hold_valid && (up_valid || up_flush);
  assign down_last  = down_valid && (up_first || up_flush);
  assign down_data  = hold_data;
  assign up_ready   = !hold_valid || down_ready;

  assign accept    = up_valid && up_ready;
  assign xfer      = down_valid && down_ready;
  assign xfer_last = xfer && down_last;

  // A packet closing on this edge means the beat accepted on the
  // same edge must itself be a first beat.
  assign expect_now = expect_first || xfer_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid   <= 1'b0;
      expect_first <= 1'b1;
      packet_count <= '0;
      err_no_first <= 1'b0;
    end else begin
      if (accept) begin
        hold_valid <= 1'b1;
      end else if (xfer) begin
        hold_valid <= 1'b0;
      end

      if (accept) begin
        expect_first <= 1'b0;
        if (expect_now && !up_first) begin
          err_no_first <= 1'b1;
        end
      end else begin
        expect_first <= expect_now;
      end

      if (xfer_last) begin
        packet_count <= packet_count + 1'b1;
      end
    end
  end

  // Payload register carries no reset; hold_valid qualifies it.
  always_ff @(posedge clock) begin
    if (accept) begin
      hold_data <= up_data;
    end
  end

endmodule

// File: tb/tb_conv_first_to_last_with_ready.sv
// Directed bench for conv_first_to_last_with_ready.
// Second instance with a 2-bit counter exercises the wrap.
module tb_conv_first_to_last_with_ready;

  logic       clock = 1'b0;
  logic       reset;
  logic       up_valid;
  logic       up_first;
  logic [7:0] up_data;
  logic       up_flush;
  logic       down_ready;

  logic        up_ready;
  logic        down_valid;
  logic        down_last;
  logic [7:0]  down_data;
  logic [15:0] packet_count;
  logic        err_no_first;

  logic       up_ready2;
  logic       down_valid2;
  logic       down_last2;
  logic [7:0] down_data2;
  logic [1:0] packet_count2;
  logic       err_no_first2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  conv_first_to_last_with_ready #(
    .width(8), .count_width(16)
  ) dut (
    .clock(clock), .reset(reset),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_first(up_first), .up_data(up_data),
    .up_flush(up_flush),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_last(down_last), .down_data(down_data),
    .packet_count(packet_count),
    .err_no_first(err_no_first)
  );

  conv_first_to_last_with_ready #(
    .width(8), .count_width(2)
  ) dut2 (
    .clock(clock), .reset(reset),
    .up_valid(up_valid), .up_ready(up_ready2),
    .up_first(up_first), .up_data(up_data),
    .up_flush(up_flush),
    .down_valid(down_valid2), .down_ready(down_ready),
    .down_last(down_last2), .down_data(down_data2),
    .packet_count(packet_count2),
    .err_no_first(err_no_first2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic f,
                       input logic [7:0] d, input logic fl);
    up_valid = v;
    up_first = f;
    up_data  = d;
    up_flush = fl;
    #1;
  endtask

  task automatic chk_down(input string tag, input logic v,
                          input logic l, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(down_valid), 32'(v));
    chk({tag, ".last"}, 32'(down_last), 32'(l));
    chk({tag, ".data"}, 32'(down_data), 32'(d));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 8'h00, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    down_ready = 1'b1;
    do_reset();
    chk("rst.down_valid", 32'(down_valid), 0);
    chk("rst.up_ready", 32'(up_ready), 1);
    chk("rst.count", 32'(packet_count), 0);
    chk("rst.err", 32'(err_no_first), 0);

    // stream 11(f) 22 33 44(f)
    drive(1, 1, 8'h11, 0);
    chk("s.empty", 32'(down_valid), 0);
    tick();
    drive(1, 0, 8'h22, 0);
    chk_down("s.b11", 1, 0, 8'h11);
    tick();
    drive(1, 0, 8'h33, 0);
    chk_down("s.b22", 1, 0, 8'h22);
    tick();
    drive(1, 1, 8'h44, 0);
    chk_down("s.b33", 1, 1, 8'h33);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("s.count", 32'(packet_count), 1);
    chk("s.held", 32'(down_data), 32'h44);
    chk("s.idle", 32'(down_valid), 0);

    // load 55, which closes 44; then flush 55
    drive(1, 1, 8'h55, 0);
    chk_down("f.b44", 1, 1, 8'h44);
    tick();
    chk("f.count1", 32'(packet_count), 2);
    drive(0, 0, 8'h00, 1);
    chk_down("f.b55", 1, 1, 8'h55);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("f.count2", 32'(packet_count), 3);
    chk("f.empty", 32'(down_valid), 0);
    chk("f.up_ready", 32'(up_ready), 1);
    drive(0, 0, 8'h00, 1);
    chk("f.flush_empty", 32'(down_valid), 0);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("f.count3", 32'(packet_count), 3);

    // backpressure
    drive(1, 1, 8'h60, 0);
    tick();
    down_ready = 1'b0;
    drive(1, 0, 8'h61, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.up_ready", 32'(up_ready), 0);
      chk("bp.data", 32'(down_data), 32'h60);
      tick();
    end
    down_ready = 1'b1;
    #1;
    chk_down("bp.b60", 1, 0, 8'h60);
    chk("bp.up_ready_rel", 32'(up_ready), 1);
    tick();
    drive(1, 0, 8'h62, 0);
    chk_down("bp.b61", 1, 0, 8'h61);
    tick();
    drive(1, 1, 8'h70, 0);
    chk_down("bp.b62", 1, 1, 8'h62);
    tick();
    drive(0, 0, 8'h00, 1);
    chk_down("bp.b70", 1, 1, 8'h70);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("bp.count", 32'(packet_count), 5);
    chk("bp.err", 32'(err_no_first), 0);

    // reset discards a held beat
    drive(1, 1, 8'h80, 0);
    tick();
    drive(0, 0, 8'h00, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r.down_valid", 32'(down_valid), 0);
    chk("r.count", 32'(packet_count), 0);
    drive(0, 0, 8'h00, 1);
    chk("r.no_emit", 32'(down_valid), 0);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("r.count2", 32'(packet_count), 0);

    // missing first beat
    drive(1, 0, 8'h01, 0);
    tick();
    chk("e.err", 32'(err_no_first), 1);
    drive(1, 1, 8'h02, 0);
    chk_down("e.b01", 1, 1, 8'h01);
    tick();
    drive(0, 0, 8'h00, 1);
    chk_down("e.b02", 1, 1, 8'h02);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("e.sticky", 32'(err_no_first), 1);
    chk("e.count", 32'(packet_count), 2);

    // 2-bit counter wrap
    do_reset();
    chk("w.err_clr", 32'(err_no_first), 0);
    chk("w.count0", 32'(packet_count2), 0);
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0;
    wrap_exp[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 8'(8'hA0 + i), 0);
      tick();
      drive(0, 0, 8'h00, 1);
      chk("w.last", 32'(down_last2), 1);
      tick();
      drive(0, 0, 8'h00, 0);
      chk("w.count", 32'(packet_count2), 32'(wrap_exp[i]));
    end
    chk("w.count16", 32'(packet_count), 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_first_to_last_with_ready.md
CONV_FIRST_TO_LAST_WITH_READY -- requirements
Module: conv_first_to_last_with_ready

Interface
REQ-001 Parameter: width, 8, bit width of up_data and down_data.
REQ-002 Parameter: count_width, 16, bit width of packet_count.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: up_valid  input  1  upstream beat present.
REQ-006 Port: up_ready  output  1  upstream beat accepted this cycle when up_valid && up_ready.
REQ-007 Port: up_first  input  1  upstream beat is the first beat of a packet.
REQ-008 Port: up_data  input  width  upstream payload.
REQ-009 Port: up_flush  input  1  end-of-stream request; closes the packet in the holding register without a following beat.
REQ-010 Port: down_valid  output  1  downstream beat present.
REQ-011 Port: down_ready  input  1  downstream accepts when down_valid && down_ready.
REQ-012 Port: down_last  output  1  downstream beat is the last beat of a packet.
REQ-013 Port: down_data  output  width  downstream payload.
REQ-014 Port: packet_count  output  count_width  number of downstream beats transferred with down_last=1.
REQ-015 Port: err_no_first  output  1  sticky protocol error flag.

Function
REQ-016 The block SHALL hold one beat in a holding register (hold_valid, hold_data); down_data SHALL equal hold_data.
REQ-017 down_valid SHALL be hold_valid && (up_valid || up_flush).
REQ-018 down_last SHALL be up_first || up_flush while down_valid is 1.
REQ-019 up_ready SHALL be !hold_valid || down_ready.
REQ-020 Accepted upstream beat: hold_data <= up_data and hold_valid <= 1 on the same edge.
REQ-021 Transfer with up_flush=1 and no upstream acceptance: hold_valid SHALL go to 0.
REQ-022 Transfer and upstream acceptance on the same edge: the held beat leaves and the new beat is loaded; hold_valid stays 1 and throughput is one beat per cycle.
REQ-023 down_ready=0 with hold_valid=1: hold_data and hold_valid SHALL remain unchanged, and up_ready SHALL be 0.
REQ-024 up_flush with hold_valid=0 SHALL have no effect.
REQ-025 up_flush together with an accepted beat: the held beat is marked last, and the new beat starts a new packet.
REQ-026 Expected-first tracking:
  - The block SHALL expect a first beat after reset and after every transfer with down_last=1.
  - An accepted beat with up_first=0 while a first beat is expected SHALL set err_no_first=1, which stays 1 until reset.
  - Data SHALL still be passed unchanged.
REQ-027 packet_count SHALL increment by 1 on each transfer with down_last=1 and wrap from 2^count_width-1 to 0.
REQ-028 Latency: every beat is emitted exactly one accepted beat, or one flush, after its acceptance; there is no fixed cycle latency.

Reset
REQ-029 While reset=1:
  - hold_valid SHALL be 0, so down_valid=0 and up_ready=1.
  - packet_count SHALL be 0 and err_no_first SHALL be 0.
  - The expected-first state SHALL be set.
REQ-030 hold_data SHALL NOT be reset.
REQ-031 Reset asserted mid-packet SHALL discard the held beat without emitting it.

Structure
REQ-032 No shared package SHALL be used; width and count_width are module parameters only.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 Stream 0x11(first),0x22,0x33,0x44(first) with down_ready=1 -> downstream 0x11/last0, 0x22/last0, 0x33/last1; 0x44 held; packet_count=1.
REQ-035 Hold 0x55, pulse up_flush with up_valid=0 -> down 0x55/last1 in that cycle; then hold_valid=0, packet_count increments.
REQ-036 down_ready=0 for 3 cycles with up_valid=1 -> up_ready=0, down_data stable; on release, one transfer per cycle with no loss or duplication.
REQ-037 First beat after reset 0x01 with up_first=0 -> err_no_first=1 and stays 1; data still delivered.
REQ-038 count_width=2, five flushed packets -> packet_count 1,2,3,0,1.
REQ-039 Reset asserted with hold_valid=1 -> next cycle down_valid=0, packet_count=0, held beat never appears.
